// File: rtl/pattern_defs_pkg.sv
// Shared definitions for the 1011 pattern-detector chain: serial source
// state encodings, the default word width and the detector's target sequence.
package pattern_defs_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [3:0] PD_SEQ = 4'b1011;

endpackage

// File: rtl/ser_hold_buf.sv
// Single-entry word register with a full flag. A write fills it and a read
// empties it; the source only writes while empty and only reads while full,
// so the two strobes never collide.
module ser_hold_buf
  import pattern_defs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data;

  // Capture a word on write, release the entry on read; reset empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr) begin
      data <= wr_data;
      full <= 1'b1;
    end else if (rd) begin
      full <= 1'b0;
    end
  end

  assign rd_data = data;

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-in/serial-out feeder: accepts WIDTH-bit words on a valid/ready
// handshake, buffers one word ahead and emits each word MSB-first with
// per-bit valid/ready. Optional macro SER_PARITY_EN appends an even-parity
// bit after every word; without it each word is exactly WIDTH bit slots.
module serial_bit_source
  import pattern_defs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [CNT_W-1:0] words_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shifter;
  logic [CW-1:0]    cnt;

  logic             hold_full;
  logic             hold_wr;
  logic             hold_rd;
  logic [WIDTH-1:0] hold_data;

  logic             accept;
  logic             fire;
  logic             last_fire;
  logic             load_direct;
  logic             load_any;
  logic [WIDTH-1:0] load_word;

  // The hold register is the only thing that can refuse a word, so readiness
  // is a pure register output.
  assign in_ready  = ~hold_full;
  assign accept    = in_valid & in_ready;

  assign ser_valid = (state == ST_SHIFT) | (state == ST_PAR);
  assign fire      = ser_valid & ser_ready;
  assign last_fire = fire & ser_last;

  // A word bypasses the hold register when the shifter is free to take it:
  // either nothing is being sent, or the current word finishes this cycle.
  assign load_direct = (state == ST_IDLE) | last_fire;
  assign hold_wr     = accept & ~load_direct;
  assign hold_rd     = last_fire & hold_full;
  assign load_any    = (accept & load_direct) | hold_rd;
  assign load_word   = hold_rd ? hold_data : in_word;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr      (hold_wr),
    .rd      (hold_rd),
    .wr_data (in_word),
    .rd_data (hold_data),
    .full    (hold_full)
  );

`ifdef SER_PARITY_EN
  logic parity;

  // Even parity of the word is latched when it enters the shifter, since the
  // shifter no longer holds all data bits by the time the parity slot arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (load_any) begin
      parity <= ^load_word;
    end
  end

  assign ser_last = (state == ST_PAR);
  assign ser_bit  = (state == ST_SHIFT) ? shifter[WIDTH-1] :
                    (state == ST_PAR)   ? parity : 1'b0;
`else
  assign ser_last = (state == ST_SHIFT) && (cnt == LAST_CNT);
  assign ser_bit  = (state == ST_SHIFT) ? shifter[WIDTH-1] : 1'b0;
`endif

  // Word sequencing: load new words, advance one bit per consumed slot and
  // chain straight into the next word without a bubble when one is waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shifter <= '0;
      cnt     <= '0;
    end else if (load_any) begin
      state   <= ST_SHIFT;
      shifter <= load_word;
      cnt     <= '0;
    end else if (last_fire) begin
      state <= ST_IDLE;
`ifdef SER_PARITY_EN
    end else if (fire && (state == ST_SHIFT) && (cnt == LAST_CNT)) begin
      state <= ST_PAR;
`endif
    end else if (fire && (state == ST_SHIFT)) begin
      shifter <= {shifter[WIDTH-2:0], 1'b0};
      cnt     <= cnt + CW'(1);
    end
  end

  // Count completed words, sticking at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_sent <= '0;
    end else if (last_fire && (words_sent != {CNT_W{1'b1}})) begin
      words_sent <= words_sent + CNT_W'(1);
    end
  end

endmodule
